// File: rtl/ram_access_controller_if.sv
// Core-side request/response handshake bundle for ram_access_controller.
// The master modport is the core; the slave modport is the controller.
interface ram_access_controller_if #(
    parameter int ADDR_WIDTH = 18
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_error;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_address, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_address, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/ram_access_controller.sv
// ram_access_controller: load/store front-end for the 32-bit, byte-addressed,
// single-port RAM. One request is in flight at a time; the RAM pins are
// registered and only change when a request is accepted or ACCESS ends.
module ram_access_controller #(
    parameter int ADDR_WIDTH  = 18,
    parameter bit ALIGN_CHECK = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    ram_access_controller_if.slave bus,
    output logic [ADDR_WIDTH-1:0]  ram_address,
    output logic [31:0]            ram_data_in,
    output logic [3:0]             ram_byte_enablers,
    output logic                   ram_write_enable,
    input  logic [31:0]            ram_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Latched request attributes needed after the accepting edge.
    logic [1:0] size_q;
    logic       signed_q;
    logic       write_q;

    logic accept;   // legal request taken in IDLE, RAM will be accessed
    logic reject;   // request taken in IDLE but answered with an error
    logic take;     // core accepts the response this cycle

    // The RAM rotators align the data, so only the enabled lanes differ by size.
    function automatic logic [3:0] enablers_for(input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001;
            2'b01:   be = 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Illegal size is always rejected; misalignment only when checking is on.
    function automatic logic bad_request(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = (size == 2'b11);
        if (ALIGN_CHECK) begin
            if (size == 2'b01 && offset[0])
                bad = 1'b1;
            if (size == 2'b10 && offset != 2'b00)
                bad = 1'b1;
        end
        return bad;
    endfunction

    // Byte 0 of the RAM output is the addressed byte; extend from bit 7 or 15.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sign);
        logic signed [7:0]  lo_byte;
        logic signed [15:0] lo_half;
        logic signed [31:0] ext;
        lo_byte = raw[7:0];
        lo_half = raw[15:0];
        case (size)
            2'b00: begin
                if (sign) ext = 32'(lo_byte);
                else      ext = {24'd0, raw[7:0]};
            end
            2'b01: begin
                if (sign) ext = 32'(lo_half);
                else      ext = {16'd0, raw[15:0]};
            end
            default: ext = raw;
        endcase
        return ext;
    endfunction

    // State register; reset aborts any access in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state decode, request acceptance and response hand-off.
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        accept        = 1'b0;
        reject        = 1'b0;
        take          = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (bad_request(bus.req_size, bus.req_address[1:0])) begin
                        reject     = 1'b1;
                        state_next = RESP;
                    end else begin
                        accept     = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS:  state_next = write_q ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    take       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request attributes; only read after an accept, so no reset is needed.
    always_ff @(posedge clock) begin
        if (accept) begin
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            write_q  <= bus.req_write;
        end
    end

    // RAM pins: loaded on accept, write enable lives only for the ACCESS cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_address       <= '0;
            ram_data_in       <= '0;
            ram_byte_enablers <= '0;
            ram_write_enable  <= 1'b0;
        end else if (accept) begin
            ram_address       <= bus.req_address;
            ram_data_in       <= bus.req_wdata;
            ram_byte_enablers <= enablers_for(bus.req_size);
            ram_write_enable  <= bus.req_write;
        end else if (state == ACCESS) begin
            ram_write_enable  <= 1'b0;
        end
    end

    // Response registers: set on error, store completion or load capture; cleared on hand-off.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.resp_valid <= 1'b0;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= '0;
        end else if (reject) begin
            bus.resp_valid <= 1'b1;
            bus.resp_error <= 1'b1;
            bus.resp_rdata <= '0;
        end else if (state == ACCESS && write_q) begin
            bus.resp_valid <= 1'b1;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= '0;
        end else if (state == WAIT) begin
            bus.resp_valid <= 1'b1;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= extend_load(ram_data_out, size_q, signed_q);
        end else if (take) begin
            bus.resp_valid <= 1'b0;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_ram_access_controller.sv
// Testbench for ram_access_controller: behavioural RAM, byte-level reference
// model, scoreboard queue filled by the driver and drained by a monitor.
`timescale 1ns/1ps
module tb_ram_access_controller;

    localparam int AW  = 18;
    localparam int MEM = 1 << AW;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Main DUT (no alignment check) with behavioural RAM.
    ram_access_controller_if #(.ADDR_WIDTH(AW)) bus ();
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_data_in;
    logic [3:0]    ram_be;
    logic          ram_we;
    logic [31:0]   ram_data_out;

    ram_access_controller #(.ADDR_WIDTH(AW), .ALIGN_CHECK(1'b0)) u_dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .bus               (bus),
        .ram_address       (ram_address),
        .ram_data_in       (ram_data_in),
        .ram_byte_enablers (ram_be),
        .ram_write_enable  (ram_we),
        .ram_data_out      (ram_data_out)
    );

    // Second DUT with alignment checking; its RAM returns a fixed word.
    ram_access_controller_if #(.ADDR_WIDTH(AW)) bus_ac ();
    logic [AW-1:0] ac_ram_address;
    logic [31:0]   ac_ram_data_in;
    logic [3:0]    ac_ram_be;
    logic          ac_ram_we;
    logic [31:0]   ac_ram_data_out;
    assign ac_ram_data_out = 32'hCAFEF00D;

    ram_access_controller #(.ADDR_WIDTH(AW), .ALIGN_CHECK(1'b1)) u_dut_ac (
        .clock             (clock),
        .reset_n           (reset_n),
        .bus               (bus_ac),
        .ram_address       (ac_ram_address),
        .ram_data_in       (ac_ram_data_in),
        .ram_byte_enablers (ac_ram_be),
        .ram_write_enable  (ac_ram_we),
        .ram_data_out      (ac_ram_data_out)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37) ^ (i >> 7));
    endfunction

    // Behavioural RAM: byte lane i maps to address A+i (wrapping), 1-cycle read.
    logic [7:0] ram_mem [MEM];
    bit ram_init_done = 1'b0;
    always @(posedge clock) begin
        if (!ram_init_done) begin
            for (int i = 0; i < MEM; i++) ram_mem[i] <= init_byte(i);
            ram_init_done <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we && ram_be[i]) ram_mem[ram_address + AW'(i)] <= ram_data_in[8*i +: 8];
                ram_data_out[8*i +: 8] <= ram_mem[ram_address + AW'(i)];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Reference model: memory as a flat byte array, responses from the rules.
    typedef struct {
        logic [31:0] rdata;
        logic        error;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    logic [7:0] ref_mem [MEM];

    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [AW-1:0] a, input logic [31:0] wd, output exp_t e);
        int n;
        logic [31:0] v;
        e.acc = 0;
        if (sz == 2'b11) begin
            e.rdata = 32'd0; e.error = 1'b1; e.lat = 1;
            return;
        end
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (w) begin
            for (int i = 0; i < n; i++) ref_mem[a + AW'(i)] = wd[8*i +: 8];
            e.rdata = 32'd0; e.error = 1'b0; e.lat = 2;
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + AW'(i)];
            if (sg && v[8*n-1])
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.rdata = v; e.error = 1'b0; e.lat = 3;
        end
    endtask

    // Driver: present a request, push the expectation on the accepting cycle.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [AW-1:0] a, input logic [31:0] wd);
        exp_t e;
        bit   done = 1'b0;
        @(posedge clock); #1;
        bus.req_valid   = 1'b1;
        bus.req_write   = w;
        bus.req_size    = sz;
        bus.req_signed  = sg;
        bus.req_address = a;
        bus.req_wdata   = wd;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                model(w, sz, sg, a, wd, e);
                e.acc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) fail_timeout("req_accept");
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || bus.resp_valid) && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (k >= 200) fail_timeout("drain");
        @(negedge clock);
    endtask

    // Response-ready generator: random, or forced during directed phases.
    bit rand_ready   = 1'b1;
    bit forced_ready = 1'b1;
    initial begin
        bus.resp_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            bus.resp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
        end
    end

    // Monitor: compare each new response, then hold it stable until taken.
    bit          seen = 1'b0;
    exp_t        mon_e;
    logic [31:0] held_rdata;
    logic        held_err;
    logic [31:0] last_rdata = '0;
    logic        last_err   = 1'b0;
    always @(negedge clock) begin
        if (reset_n && bus.resp_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got rdata 0x%08h error %0d, expected none",
                             bus.resp_rdata, bus.resp_error);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_rdata", bus.resp_rdata, mon_e.rdata);
                    check("resp_error", 32'(bus.resp_error), 32'(mon_e.error));
                    check("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                end
                held_rdata = bus.resp_rdata;
                held_err   = bus.resp_error;
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_error;
            end else begin
                check("resp_rdata_stable", bus.resp_rdata, held_rdata);
                check("resp_error_stable", 32'(bus.resp_error), 32'(held_err));
            end
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
            if (bus.resp_ready) seen = 1'b0;
        end
    end

    // Write-enable activity, sampled mid-cycle.
    int         we_cycles    = 0;
    int         ac_we_cycles = 0;
    logic [3:0] we_be        = '0;
    always @(negedge clock) begin
        if (ram_we) begin
            we_cycles++;
            we_be = ram_be;
        end
        if (ac_ram_we) ac_we_cycles++;
    end

    // Directed access on the alignment-checking instance.
    task automatic ac_access(input string name, input logic [1:0] sz, input logic sg,
                             input logic [AW-1:0] a, input logic exp_err,
                             input logic [31:0] exp_rd, input int exp_lat);
        int a_cyc;
        bit got = 1'b0;
        @(posedge clock); #1;
        bus_ac.req_valid   = 1'b1;
        bus_ac.req_write   = 1'b0;
        bus_ac.req_size    = sz;
        bus_ac.req_signed  = sg;
        bus_ac.req_address = a;
        bus_ac.req_wdata   = 32'd0;
        @(negedge clock);
        check({name, "_ready"}, 32'(bus_ac.req_ready), 32'd1);
        a_cyc = cyc;
        @(posedge clock); #1;
        bus_ac.req_valid = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clock);
            if (bus_ac.resp_valid) got = 1'b1;
        end
        if (!got) fail_timeout(name);
        else begin
            check({name, "_latency"}, 32'(cyc - a_cyc), 32'(exp_lat));
            check({name, "_error"}, 32'(bus_ac.resp_error), 32'(exp_err));
            check({name, "_rdata"}, bus_ac.resp_rdata, exp_rd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          we0;
        int          ac_we0;
        logic [AW-1:0] a;
        logic [1:0]  sz;
        bit          got;

        for (int i = 0; i < MEM; i++) ref_mem[i] = init_byte(i);
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_address = '0; bus.req_wdata = '0;
        bus_ac.req_valid = 1'b0; bus_ac.req_write = 1'b0; bus_ac.req_size = 2'b00;
        bus_ac.req_signed = 1'b0; bus_ac.req_address = '0; bus_ac.req_wdata = '0;
        bus_ac.resp_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_error", 32'(bus.resp_error), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_be", 32'(ram_be), 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        check("rst_ram_data_in", ram_data_in, 32'd0);
        reset_n = 1'b1;

        // Word store then word load
        we0 = we_cycles;
        issue(1'b1, 2'b10, 1'b0, 18'h00100, 32'hDEADBEEF);
        drain();
        check("store_we_cycles", 32'(we_cycles - we0), 32'd1);
        check("store_be", 32'(we_be), 32'hF);
        issue(1'b0, 2'b10, 1'b0, 18'h00100, 32'd0);
        drain();
        check("word_load", last_rdata, 32'hDEADBEEF);

        // Reset during the ACCESS cycle of a store drops the write
        @(posedge clock); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_address = 18'h00100; bus.req_wdata = 32'h11223344;
        @(negedge clock);
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        check("abort_we_access", 32'(ram_we), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_we_dropped", 32'(ram_we), 32'd0);
        check("abort_ram_address", 32'(ram_address), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        issue(1'b0, 2'b10, 1'b0, 18'h00100, 32'd0);
        drain();
        check("abort_old_value", last_rdata, 32'hDEADBEEF);

        // Signed and unsigned byte loads
        issue(1'b1, 2'b00, 1'b0, 18'h00103, 32'hABCDEF80);
        issue(1'b0, 2'b00, 1'b1, 18'h00103, 32'd0);
        drain();
        check("byte_signed", last_rdata, 32'hFFFFFF80);
        issue(1'b0, 2'b00, 1'b0, 18'h00103, 32'd0);
        drain();
        check("byte_unsigned", last_rdata, 32'h00000080);

        // Misaligned signed half load
        issue(1'b1, 2'b10, 1'b0, 18'h00100, 32'h12F45678);
        issue(1'b0, 2'b01, 1'b1, 18'h00101, 32'd0);
        drain();
        check("half_misaligned", last_rdata, 32'hFFFFF456);

        // Illegal size: error, no RAM write
        we0 = we_cycles;
        issue(1'b1, 2'b11, 1'b0, 18'h00100, 32'h0BADF00D);
        drain();
        check("illegal_error", 32'(last_err), 32'd1);
        check("illegal_no_write", 32'(we_cycles - we0), 32'd0);
        issue(1'b0, 2'b10, 1'b0, 18'h00100, 32'd0);
        drain();
        check("illegal_mem_intact", last_rdata, 32'h12F45678);

        // Address wrap
        issue(1'b1, 2'b10, 1'b0, 18'h3FFFF, 32'hA5B6C7D8);
        issue(1'b0, 2'b10, 1'b0, 18'h3FFFF, 32'd0);
        drain();
        check("wrap_word", last_rdata, 32'hA5B6C7D8);

        // Backpressure: response held five cycles, new request ignored
        rand_ready = 1'b0;
        forced_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 18'h00100, 32'd0);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clock);
            if (bus.resp_valid) got = 1'b1;
        end
        if (!got) fail_timeout("bp_resp");
        @(posedge clock); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_address = 18'h00200; bus.req_wdata = 32'h55555555;
        we0 = we_cycles;
        repeat (5) begin
            @(negedge clock);
            check("bp_valid_held", 32'(bus.resp_valid), 32'd1);
            check("bp_rdata_held", bus.resp_rdata, 32'h12F45678);
        end
        check("bp_no_access", 32'(we_cycles - we0), 32'd0);
        check("bp_address_held", 32'(ram_address), 32'h00100);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        forced_ready = 1'b1;
        drain();
        rand_ready = 1'b1;

        // Alignment-checking instance
        ac_we0 = ac_we_cycles;
        ac_access("ac_word_102", 2'b10, 1'b0, 18'h00102, 1'b1, 32'd0, 1);
        ac_access("ac_half_101", 2'b01, 1'b1, 18'h00101, 1'b1, 32'd0, 1);
        ac_access("ac_word_104", 2'b10, 1'b0, 18'h00104, 1'b0, 32'hCAFEF00D, 3);
        check("ac_ram_address", 32'(ac_ram_address), 32'h00104);
        check("ac_ram_be", 32'(ac_ram_be), 32'hF);
        check("ac_ram_data_in", ac_ram_data_in, 32'd0);
        ac_access("ac_half_s_102", 2'b01, 1'b1, 18'h00102, 1'b0, 32'hFFFFF00D, 3);
        ac_access("ac_half_u_102", 2'b01, 1'b0, 18'h00102, 1'b0, 32'h0000F00D, 3);
        check("ac_no_write", 32'(ac_we_cycles - ac_we0), 32'd0);

        // Random traffic against the reference model
        for (int t = 0; t < 300; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 7) == 0) ? AW'(32'h3FFFC + $urandom_range(0, 3))
                                             : AW'(32'h00100 + $urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        drain();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_access_controller.md
Name: ram_access_controller

Overview:
- Load/store front-end placed directly upstream of the 32-bit, byte-addressed, single-port RAM (18-bit address, 4 byte enablers, one write enable, 1-cycle synchronous read).
- Accepts one core memory request at a time through a valid/ready handshake and registers the request.
- Drives the RAM address, data, byte-enabler and write-enable pins, and waits out the RAM read latency.
- Zero- or sign-extends load data, then returns a response through a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 18, byte address width; must match the RAM address width.
- ALIGN_CHECK, 0. When 1, a misaligned half or word access is rejected with an error. When 0, it is passed through, because the RAM rotators handle any offset.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_address  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  request rejected; the RAM was not accessed.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_data_in  out  32  to RAM data_in.
- ram_byte_enablers  out  4  to RAM byte_enablers.
- ram_write_enable  out  1  to RAM write_enable.
- ram_data_out  in  32  from RAM data_out.

Behaviour:
- Reset (async assert, sync release) sets these values:
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_error = 0.
  - ram_write_enable = 0, ram_byte_enablers = 0, ram_address = 0, ram_data_in = 0.
  - Reset mid-operation aborts the access immediately. A pending write is dropped if reset asserts before the ACCESS clock edge.
- RAM outputs are registered and are held constant outside ACCESS. ram_write_enable is 1 only in ACCESS for a store.
- Byte enablers by size: byte 0001, half 0011, word 1111. ram_data_in = the registered req_wdata.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the request and go to ACCESS.
  - Exception: if req_size = 11, or ALIGN_CHECK = 1 and the access is misaligned (half with address[0] = 1, word with address[1:0] != 0), go to RESP with resp_error = 1 and do not touch the RAM.
- ACCESS (1 cycle, req_ready = 0):
  - RAM pins present the latched request; the RAM samples at the end of this cycle.
  - Store: next state RESP.
  - Load: next state WAIT.
- WAIT (1 cycle):
  - Capture ram_data_out, with byte [7:0] at address A, [15:8] at A+1, and so on.
  - Extend from bit 7 (byte) or bit 15 (half); word is passed unchanged.
  - Register the result into resp_rdata. Next state RESP.
- RESP:
  - resp_valid = 1, with resp_rdata and resp_error stable.
  - On resp_ready = 1: clear resp_valid, resp_error and resp_rdata at that edge, then go to IDLE. req_ready returns to 1 in the following cycle; no same-cycle turnaround.
  - Stall indefinitely while resp_ready = 0.
- Latency, counted from the accepting edge: a load response is visible 3 cycles later, a store 2 cycles later, an error 1 cycle later.
- Addresses wrap: an access at 0x3FFFF with size word is issued unchanged; wrap is handled by the RAM.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Reset check: assert reset_n = 0 mid-ACCESS of a store → ram_write_enable drops to 0 immediately, and a subsequent load of that address returns the old value. After release, req_ready = 1 and resp_valid = 0.
- Word store then word load: store 0xDEADBEEF at 0x00100 (ram_byte_enablers = 1111 and ram_write_enable = 1 for exactly one cycle), then load the word at 0x00100 → resp_rdata = 0xDEADBEEF, valid 3 cycles after acceptance.
- Signed byte load: store byte 0x80 at 0x00103, then load byte signed → 0xFFFFFF80; unsigned → 0x00000080.
- Half load: load half signed at 0x00101 after storing word 0x12F45678 at 0x00100 → 0xFFFFF456 (misaligned access, ALIGN_CHECK = 0).
- Errors: req_size = 11 → resp_error = 1 one cycle after acceptance with no RAM write. With ALIGN_CHECK = 1, a word at 0x00102 → error.
- Backpressure: hold resp_ready = 0 for 5 cycles → resp_valid and resp_rdata stay stable, req_ready = 0, and a new req_valid is ignored until the response is taken.
